csi2_tx_frame_sequencer: RTL and testbench

- Sequences one CSI-2 frame into the `tx_dphy` packet interface: HS clock start, Frame Start short packet, NUM_LINES long pixel packets, Frame End short packet, HS clock stop.
- Sits between the test-pattern/pixel source and the `tx_dphy` instance.
- Drives the packet-control and header inputs of `tx_dphy`.
- Consumes `tinit_done`, `d_hs_rdy` and `ld_pyld` from `tx_dphy`.

---
 rtl/csi2_tx_frame_sequencer_pkg.sv | 26 ++
 rtl/csi2_tx_frame_sequencer_if.sv | 27 ++
 rtl/csi2_tx_frame_sequencer_gap_timer.sv | 27 ++
 rtl/csi2_tx_frame_sequencer.sv | 178 +++++++++++++++++
 tb/tb_csi2_tx_frame_sequencer.sv | 368 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/csi2_tx_frame_sequencer_pkg.sv
// Shared CSI-2 transmit definitions: sequencer states, packet data types and
// the frame-number wrap rule.
package csi2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLK_PRE,
        ST_FS_REQ,
        ST_GAP,
        ST_LINE_REQ,
        ST_PAYLOAD,
        ST_FE_REQ,
        ST_CLK_POST
    } state_t;

    localparam logic [5:0] DT_FS       = 6'h00;
    localparam logic [5:0] DT_FE       = 6'h01;
    localparam logic [5:0] DT_YUV422_8 = 6'h1E;
    localparam logic [5:0] DT_RAW8     = 6'h2A;

    // Frame number 0 is reserved, so the count wraps back to 1.
    function automatic logic [15:0] next_frame_num(input logic [15:0] cur);
        return (cur == 16'hFFFF) ? 16'h0001 : cur + 16'h0001;
    endfunction

endpackage

// File: rtl/csi2_tx_frame_sequencer_if.sv
// Packet-control and payload handshake between the frame sequencer and tx_dphy.
interface csi2_tx_frame_sequencer_if;

    logic       d_hs_rdy_i;
    logic       ld_pyld_i;
    logic       clk_hs_en_o;
    logic       d_hs_en_o;
    logic       sp_en_o;
    logic       lp_en_o;
    logic       byte_data_en_o;
    logic [5:0] dt_o;
    logic [1:0] vc_o;
    logic [15:0] wc_o;

    modport master (
        input  d_hs_rdy_i, ld_pyld_i,
        output clk_hs_en_o, d_hs_en_o, sp_en_o, lp_en_o, byte_data_en_o,
               dt_o, vc_o, wc_o
    );

    modport slave (
        output d_hs_rdy_i, ld_pyld_i,
        input  clk_hs_en_o, d_hs_en_o, sp_en_o, lp_en_o, byte_data_en_o,
               dt_o, vc_o, wc_o
    );

endinterface

// File: rtl/csi2_tx_frame_sequencer_gap_timer.sv
// Loadable down-counter; a load of N-1 keeps done low for N-1 cycles, so the
// owning state lasts exactly N cycles.
module csi2_gap_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - WIDTH'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/csi2_tx_frame_sequencer.sv
// Sequences one CSI-2 frame (clock start, FS, NUM_LINES long packets, FE,
// clock stop) into the tx_dphy packet interface.
module csi2_tx_frame_sequencer
    import csi2_pkg::*;
#(
    parameter int unsigned NUM_LINES  = 480,
    parameter int unsigned LINE_WC    = 1280,
    parameter logic [5:0]  DT_PIXEL   = DT_YUV422_8,
    parameter logic [1:0]  VC         = 2'd0,
    parameter int unsigned T_CLK_PRE  = 16,
    parameter int unsigned T_CLK_POST = 16,
    parameter int unsigned T_GAP      = 32
) (
    input  logic                         byte_clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic                         tinit_done_i,
    csi2_tx_frame_sequencer_if.master    pkt,
    output logic [11:0]                  line_o,
    output logic                         busy_o,
    output logic                         frame_done_o
);

    localparam int unsigned WORDS = LINE_WC / 8;
    localparam int unsigned WCW   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned T_MAX_A = (T_CLK_PRE > T_CLK_POST) ? T_CLK_PRE : T_CLK_POST;
    localparam int unsigned T_MAX   = (T_MAX_A > T_GAP) ? T_MAX_A : T_GAP;
    localparam int unsigned TW      = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    state_t          state;
    logic            start_pending;
    logic            after_fs;
    logic [WCW-1:0]  word_cnt;
    logic [15:0]     frame_cnt;
    logic [15:0]     frame_cnt_next;

    logic            launch;
    logic            last_word;
    logic            timer_load;
    logic [TW-1:0]   timer_val;
    logic            timer_done;

    csi2_gap_timer #(.WIDTH(TW)) u_timer (
        .clk      (byte_clk_i),
        .rst      (rst_i),
        .load     (timer_load),
        .load_val (timer_val),
        .done     (timer_done)
    );

    // Timer is loaded on the transition into each timed state so that its
    // first count lines up with the state's first cycle.
    always_comb begin
        launch         = tinit_done_i && (start_i || start_pending);
        last_word      = pkt.ld_pyld_i && (word_cnt == WCW'(WORDS - 1));
        timer_load     = 1'b0;
        timer_val      = '0;
        frame_cnt_next = frame_cnt;
        case (state)
            ST_IDLE: if (launch) begin
                timer_load = 1'b1;
                timer_val  = TW'(T_CLK_PRE - 1);
            end
            ST_FS_REQ: if (pkt.d_hs_rdy_i) begin
                timer_load = 1'b1;
                timer_val  = TW'(T_GAP - 1);
            end
            ST_PAYLOAD: if (last_word) begin
                timer_load = 1'b1;
                timer_val  = TW'(T_GAP - 1);
            end
            ST_FE_REQ: if (pkt.d_hs_rdy_i) begin
                timer_load = 1'b1;
                timer_val  = TW'(T_CLK_POST - 1);
            end
            ST_CLK_POST: if (timer_done) begin
                frame_cnt_next = next_frame_num(frame_cnt);
            end
            default: ;
        endcase
    end

    assign pkt.byte_data_en_o = (state == ST_PAYLOAD) && pkt.ld_pyld_i;

    always_ff @(posedge byte_clk_i) begin
        if (rst_i) begin
            state           <= ST_IDLE;
            start_pending   <= 1'b0;
            after_fs        <= 1'b0;
            word_cnt        <= '0;
            frame_cnt       <= 16'h0001;
            pkt.clk_hs_en_o <= 1'b0;
            pkt.d_hs_en_o   <= 1'b0;
            pkt.sp_en_o     <= 1'b0;
            pkt.lp_en_o     <= 1'b0;
            pkt.dt_o        <= '0;
            pkt.vc_o        <= VC;
            pkt.wc_o        <= '0;
            line_o          <= '0;
            busy_o          <= 1'b0;
            frame_done_o    <= 1'b0;
        end else begin
            frame_cnt    <= frame_cnt_next;
            frame_done_o <= 1'b0;
            pkt.vc_o     <= VC;
            case (state)
                ST_IDLE: begin
                    if (launch) begin
                        state           <= ST_CLK_PRE;
                        start_pending   <= 1'b0;
                        pkt.clk_hs_en_o <= 1'b1;
                        busy_o          <= 1'b1;
                        line_o          <= '0;
                    end else if (start_i) begin
                        start_pending <= 1'b1;
                    end
                end
                ST_CLK_PRE: if (timer_done) begin
                    state         <= ST_FS_REQ;
                    pkt.d_hs_en_o <= 1'b1;
                    pkt.sp_en_o   <= 1'b1;
                    pkt.dt_o      <= DT_FS;
                    pkt.wc_o      <= frame_cnt;
                end
                ST_FS_REQ: if (pkt.d_hs_rdy_i) begin
                    state         <= ST_GAP;
                    after_fs      <= 1'b1;
                    pkt.d_hs_en_o <= 1'b0;
                    pkt.sp_en_o   <= 1'b0;
                end
                ST_GAP: if (timer_done) begin
                    if (!after_fs) begin
                        line_o <= line_o + 12'd1;
                    end
                    after_fs <= 1'b0;
                    if (!after_fs && (line_o == 12'(NUM_LINES - 1))) begin
                        state         <= ST_FE_REQ;
                        pkt.d_hs_en_o <= 1'b1;
                        pkt.sp_en_o   <= 1'b1;
                        pkt.dt_o      <= DT_FE;
                        pkt.wc_o      <= frame_cnt;
                    end else begin
                        state         <= ST_LINE_REQ;
                        pkt.d_hs_en_o <= 1'b1;
                        pkt.lp_en_o   <= 1'b1;
                        pkt.dt_o      <= DT_PIXEL;
                        pkt.wc_o      <= 16'(LINE_WC);
                    end
                end
                ST_LINE_REQ: if (pkt.d_hs_rdy_i) begin
                    state         <= ST_PAYLOAD;
                    word_cnt      <= '0;
                    pkt.d_hs_en_o <= 1'b0;
                    pkt.lp_en_o   <= 1'b0;
                end
                ST_PAYLOAD: if (pkt.ld_pyld_i) begin
                    word_cnt <= word_cnt + WCW'(1);
                    if (last_word) begin
                        state <= ST_GAP;
                    end
                end
                ST_FE_REQ: if (pkt.d_hs_rdy_i) begin
                    state         <= ST_CLK_POST;
                    pkt.d_hs_en_o <= 1'b0;
                    pkt.sp_en_o   <= 1'b0;
                end
                ST_CLK_POST: if (timer_done) begin
                    state           <= ST_IDLE;
                    pkt.clk_hs_en_o <= 1'b0;
                    busy_o          <= 1'b0;
                    frame_done_o    <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csi2_tx_frame_sequencer.sv
// Directed self-checking bench for csi2_tx_frame_sequencer with a 2-line,
// 32-byte-per-line frame and short timing parameters.
module tb_csi2_tx_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        tinit;
    logic [11:0] line;
    logic        busy;
    logic        frame_done;

    int checks   = 0;
    int failures = 0;

    csi2_tx_frame_sequencer_if pkt_if ();

    csi2_tx_frame_sequencer #(
        .NUM_LINES  (2),
        .LINE_WC    (32),
        .DT_PIXEL   (6'h1E),
        .VC         (2'd0),
        .T_CLK_PRE  (4),
        .T_CLK_POST (4),
        .T_GAP      (3)
    ) dut (
        .byte_clk_i   (clk),
        .rst_i        (rst),
        .start_i      (start),
        .tinit_done_i (tinit),
        .pkt          (pkt_if),
        .line_o       (line),
        .busy_o       (busy),
        .frame_done_o (frame_done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // Hand-derived timeline of one frame, k = cycles after the start edge:
    // {clk_hs_en, d_hs_en, sp_en, lp_en, byte_data_en, frame_done, busy}
    function automatic logic [6:0] exp_ctrl(input int k);
        logic chs, dhs, sp, lp, bde, fd, bsy;
        chs = (k <= 28);
        dhs = (k == 4) || (k == 8) || (k == 16) || (k == 24);
        sp  = (k == 4) || (k == 24);
        lp  = (k == 8) || (k == 16);
        bde = (k >= 9 && k <= 12) || (k >= 17 && k <= 20);
        fd  = (k == 29);
        bsy = (k <= 28);
        return {chs, dhs, sp, lp, bde, fd, bsy};
    endfunction

    // Runs until frame_done, capturing FS/FE word counts; no checking here.
    task automatic run_frame(input bit do_start, output logic [15:0] fs_wc,
                             output logic [15:0] fe_wc, output bit done);
        fs_wc = 16'h0000;
        fe_wc = 16'h0000;
        done  = 1'b0;
        if (do_start) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        for (int c = 0; c < 300 && !done; c++) begin
            if (pkt_if.d_hs_en_o && pkt_if.sp_en_o && pkt_if.d_hs_rdy_i) begin
                if (pkt_if.dt_o == 6'h00) fs_wc = pkt_if.wc_o;
                else if (pkt_if.dt_o == 6'h01) fe_wc = pkt_if.wc_o;
            end
            if (frame_done) done = 1'b1;
            else tick();
        end
    endtask

    task automatic test_reset;
        logic [47:0] obs;
        rst = 1'b1;
        tick();
        tick();
        obs = {pkt_if.clk_hs_en_o, pkt_if.d_hs_en_o, pkt_if.sp_en_o, pkt_if.lp_en_o,
               pkt_if.byte_data_en_o, pkt_if.dt_o, pkt_if.vc_o, pkt_if.wc_o, line,
               busy, frame_done};
        checks++;
        if (obs !== 48'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=%h", obs, 48'h0);
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({busy, pkt_if.clk_hs_en_o} !== 2'b00) begin
            failures++;
            $display("FAIL reset_idle got=%b want=00", {busy, pkt_if.clk_hs_en_o});
        end
    endtask

    task automatic test_full_frame;
        logic [6:0] obs;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k <= 29; k++) begin
            obs = {pkt_if.clk_hs_en_o, pkt_if.d_hs_en_o, pkt_if.sp_en_o, pkt_if.lp_en_o,
                   pkt_if.byte_data_en_o, frame_done, busy};
            checks++;
            if (obs !== exp_ctrl(k)) begin
                failures++;
                $display("FAIL frame_ctrl k=%0d got=%b want=%b", k, obs, exp_ctrl(k));
            end
            if (k == 4 || k == 24) begin
                checks++;
                if ({pkt_if.dt_o, pkt_if.wc_o} !== {(k == 4) ? 6'h00 : 6'h01, 16'h0001}) begin
                    failures++;
                    $display("FAIL frame_short k=%0d got dt=%h wc=%h want dt=%h wc=0001",
                             k, pkt_if.dt_o, pkt_if.wc_o, (k == 4) ? 6'h00 : 6'h01);
                end
            end
            if (k == 8 || k == 16) begin
                checks++;
                if ({pkt_if.dt_o, pkt_if.wc_o, line} !== {6'h1E, 16'd32, (k == 8) ? 12'd0 : 12'd1}) begin
                    failures++;
                    $display("FAIL frame_long k=%0d got dt=%h wc=%0d line=%0d want dt=1e wc=32 line=%0d",
                             k, pkt_if.dt_o, pkt_if.wc_o, line, (k == 8) ? 0 : 1);
                end
            end
            if (k < 29) tick();
        end
    endtask

    task automatic test_second_frame;
        logic [15:0] fs, fe;
        bit          done;
        tick();
        run_frame(1'b1, fs, fe, done);
        checks++;
        if ({done, fs, fe} !== {1'b1, 16'h0002, 16'h0002}) begin
            failures++;
            $display("FAIL second_frame got done=%0b fs=%h fe=%h want done=1 fs=0002 fe=0002", done, fs, fe);
        end
    endtask

    task automatic test_tinit_pending;
        logic [15:0] fs, fe;
        bit          done;
        tick();
        tinit = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({pkt_if.clk_hs_en_o, busy, pkt_if.d_hs_en_o} !== 3'b000) begin
                failures++;
                $display("FAIL tinit_wait i=%0d got=%b want=000", i,
                         {pkt_if.clk_hs_en_o, busy, pkt_if.d_hs_en_o});
            end
            tick();
        end
        tinit = 1'b1;
        checks++;
        if (pkt_if.clk_hs_en_o !== 1'b0) begin
            failures++;
            $display("FAIL tinit_rise_same got=%b want=0", pkt_if.clk_hs_en_o);
        end
        tick();
        checks++;
        if ({pkt_if.clk_hs_en_o, busy} !== 2'b11) begin
            failures++;
            $display("FAIL tinit_launch got=%b want=11", {pkt_if.clk_hs_en_o, busy});
        end
        run_frame(1'b0, fs, fe, done);
        checks++;
        if ({done, fs} !== {1'b1, 16'h0003}) begin
            failures++;
            $display("FAIL tinit_frame got done=%0b fs=%h want done=1 fs=0003", done, fs);
        end
    endtask

    task automatic test_rdy_stall;
        logic [15:0] fs, fe;
        bit          done;
        bit          found;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (pkt_if.d_hs_en_o && pkt_if.sp_en_o) found = 1'b1;
            else tick();
        end
        tick();
        pkt_if.d_hs_rdy_i = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (pkt_if.lp_en_o) found = 1'b1;
            else tick();
        end
        checks++;
        if (found !== 1'b1) begin
            failures++;
            $display("FAIL stall_reach_line got=%0b want=1", found);
        end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if ({pkt_if.d_hs_en_o, pkt_if.lp_en_o, pkt_if.byte_data_en_o, pkt_if.dt_o, pkt_if.wc_o}
                    !== {3'b110, 6'h1E, 16'd32}) begin
                failures++;
                $display("FAIL stall_hold i=%0d got en=%b dt=%h wc=%0d want en=110 dt=1e wc=32", i,
                         {pkt_if.d_hs_en_o, pkt_if.lp_en_o, pkt_if.byte_data_en_o}, pkt_if.dt_o, pkt_if.wc_o);
            end
            tick();
        end
        pkt_if.d_hs_rdy_i = 1'b1;
        checks++;
        if ({pkt_if.d_hs_en_o, pkt_if.lp_en_o, pkt_if.byte_data_en_o} !== 3'b110) begin
            failures++;
            $display("FAIL stall_rdy_cycle got=%b want=110",
                     {pkt_if.d_hs_en_o, pkt_if.lp_en_o, pkt_if.byte_data_en_o});
        end
        tick();
        checks++;
        if ({pkt_if.d_hs_en_o, pkt_if.lp_en_o, pkt_if.byte_data_en_o} !== 3'b001) begin
            failures++;
            $display("FAIL stall_payload got=%b want=001",
                     {pkt_if.d_hs_en_o, pkt_if.lp_en_o, pkt_if.byte_data_en_o});
        end
        run_frame(1'b0, fs, fe, done);
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL stall_frame_done got=%0b want=1", done);
        end
    endtask

    task automatic test_ld_toggle;
        logic [15:0] fs, fe;
        bit          done;
        bit          found;
        bit          exp;
        int          pulses;
        tick();
        pkt_if.ld_pyld_i = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            if (pkt_if.lp_en_o) found = 1'b1;
            else tick();
        end
        tick();
        pulses = 0;
        for (int i = 0; i < 11; i++) begin
            pkt_if.ld_pyld_i = (i % 2 == 0);
            #1;
            exp = (i < 7) && (i % 2 == 0);
            if (pkt_if.byte_data_en_o === 1'b1) pulses++;
            checks++;
            if (pkt_if.byte_data_en_o !== exp) begin
                failures++;
                $display("FAIL ld_toggle i=%0d got=%b want=%b", i, pkt_if.byte_data_en_o, exp);
            end
            tick();
        end
        checks++;
        if (pulses != 4) begin
            failures++;
            $display("FAIL ld_pulse_count got=%0d want=4", pulses);
        end
        pkt_if.ld_pyld_i = 1'b1;
        run_frame(1'b0, fs, fe, done);
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL ld_frame_done got=%0b want=1", done);
        end
    endtask

    task automatic test_frame_cnt_wrap;
        logic [15:0] fs, fe;
        bit          done;
        tick();
        force dut.frame_cnt = 16'hFFFF;
        tick();
        tick();
        release dut.frame_cnt;
        tick();
        run_frame(1'b1, fs, fe, done);
        checks++;
        if ({done, fs, fe} !== {1'b1, 16'hFFFF, 16'hFFFF}) begin
            failures++;
            $display("FAIL wrap_ffff got done=%0b fs=%h fe=%h want done=1 fs=ffff fe=ffff", done, fs, fe);
        end
        tick();
        run_frame(1'b1, fs, fe, done);
        checks++;
        if ({done, fs, fe} !== {1'b1, 16'h0001, 16'h0001}) begin
            failures++;
            $display("FAIL wrap_0001 got done=%0b fs=%h fe=%h want done=1 fs=0001 fe=0001", done, fs, fe);
        end
    endtask

    task automatic test_reset_mid_payload;
        logic [15:0] fs, fe;
        logic [47:0] obs;
        bit          done;
        bit          found;
        tick();
        run_frame(1'b1, fs, fe, done);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            if (pkt_if.byte_data_en_o) found = 1'b1;
            else tick();
        end
        tick();
        checks++;
        if ({found, pkt_if.byte_data_en_o} !== 2'b11) begin
            failures++;
            $display("FAIL rst_word2 got=%b want=11", {found, pkt_if.byte_data_en_o});
        end
        rst = 1'b1;
        tick();
        obs = {pkt_if.clk_hs_en_o, pkt_if.d_hs_en_o, pkt_if.sp_en_o, pkt_if.lp_en_o,
               pkt_if.byte_data_en_o, pkt_if.dt_o, pkt_if.vc_o, pkt_if.wc_o, line,
               busy, frame_done};
        checks++;
        if (obs !== 48'h0) begin
            failures++;
            $display("FAIL rst_mid_outputs got=%h want=%h", obs, 48'h0);
        end
        rst = 1'b0;
        tick();
        run_frame(1'b1, fs, fe, done);
        checks++;
        if ({done, fs, fe} !== {1'b1, 16'h0001, 16'h0001}) begin
            failures++;
            $display("FAIL rst_clean_frame got done=%0b fs=%h fe=%h want done=1 fs=0001 fe=0001", done, fs, fe);
        end
    endtask

    initial begin
        rst              = 1'b1;
        start            = 1'b0;
        tinit            = 1'b1;
        pkt_if.d_hs_rdy_i = 1'b1;
        pkt_if.ld_pyld_i  = 1'b1;
        test_reset();
        test_full_frame();
        test_second_frame();
        test_tinit_pending();
        test_rdy_stall();
        test_ld_toggle();
        test_frame_cnt_wrap();
        test_reset_mid_payload();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
